// File: rtl/som_sub_pkg.sv
// som_sub_pkg: shared widths, opcodes, FSM states and the no-label marker for the add/sub unit
package som_sub_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 3;
  localparam int LABEL_W = 3;
  localparam logic [2:0] OP_SOM = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [8:0] NO_LABEL = 9'h1FF;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} som_sub_state_t;
endpackage

// File: rtl/som_sub_delay.sv
// som_sub_delay: down-counter loaded with LATENCY-1 on accept, flags expiry at zero
module som_sub_delay #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= 4'(LATENCY - 1);
    else if (cnt != '0) cnt <= cnt - 4'd1;
  assign expired = cnt == '0;
endmodule

// File: rtl/som_sub_unit.sv
// som_sub_unit: Tomasulo add/sub unit; define SOM_SUB_OVF_EN to add the carry/borrow output ovf
module som_sub_unit #(
  parameter int DATA_W = som_sub_pkg::DATA_W,
  parameter int ADDR_W = som_sub_pkg::ADDR_W,
  parameter int LABEL_W = som_sub_pkg::LABEL_W,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [DATA_W-1:0]  reg_x,
  input  logic [DATA_W-1:0]  reg_y,
  input  logic [DATA_W-1:0]  reg_z,
  input  logic [2:0]         op,
  input  logic [ADDR_W-1:0]  in_addr_x,
  input  logic [LABEL_W-1:0] in_label,
  output logic [DATA_W-1:0]  result,
  output logic               done,
  output logic [ADDR_W-1:0]  out_addr_x,
  output logic [LABEL_W-1:0] out_label,
  output logic               busy
`ifdef SOM_SUB_OVF_EN
  ,
  output logic               ovf
`endif
);
  import som_sub_pkg::*;
`ifdef SOM_SUB_OVF_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif
  som_sub_state_t state, state_nx;
  logic [2:0] op_q;
  logic [DATA_W-1:0] y_q, z_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LABEL_W-1:0] label_q;
  logic [RW-1:0] alu;
  logic accept, fire, expired, unused_x;
  assign unused_x = ^reg_x;
  assign accept = state == S_IDLE && run;
  assign fire = state == S_EXEC && expired;
  assign done = state == S_DONE;
  assign busy = state != S_IDLE;
  assign alu = op_q == OP_SOM ? RW'(y_q) + RW'(z_q) : op_q == OP_SUB ? RW'(y_q) - RW'(z_q) : '0;
  always_comb
    state_nx = state == S_IDLE ? (run ? S_EXEC : S_IDLE) :
               state == S_EXEC ? (expired ? S_DONE : S_EXEC) : S_IDLE;
  som_sub_delay #(.LATENCY(LATENCY)) u_delay (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= '0;
      y_q <= '0;
      z_q <= '0;
      addr_q <= '0;
      label_q <= '0;
      result <= '0;
      out_addr_x <= '0;
      out_label <= '0;
`ifdef SOM_SUB_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= op;
        y_q <= reg_y;
        z_q <= reg_z;
        addr_q <= in_addr_x;
        label_q <= in_label;
      end
      if (fire) begin
        result <= alu[DATA_W-1:0];
        out_addr_x <= addr_q;
        out_label <= label_q;
`ifdef SOM_SUB_OVF_EN
        ovf <= alu[DATA_W];
`endif
      end
    end
endmodule

// File: tb/tb_som_sub_unit.sv
// tb_som_sub_unit: randomized scoreboard bench for som_sub_unit against an arithmetic reference model
module tb_som_sub_unit;
  localparam int LAT = 2;
  typedef struct {
    logic [8:0] res;
    logic [2:0] a;
    logic [2:0] l;
    logic       ovf;
    int         due;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, run = 1'b0;
  logic [8:0] reg_x = '0, reg_y = '0, reg_z = '0;
  logic [2:0] op = '0, in_addr_x = '0, in_label = '0;
  logic [8:0] result;
  logic done, busy;
  logic [2:0] out_addr_x, out_label;
`ifdef SOM_SUB_OVF_EN
  logic ovf;
`endif
  exp_t q[$];
  exp_t last;
  int cyc = 0, tests = 0, fails = 0;
  logic mon_busy, mon_done;
  som_sub_unit #(.LATENCY(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .reg_x(reg_x),
    .reg_y(reg_y),
    .reg_z(reg_z),
    .op(op),
    .in_addr_x(in_addr_x),
    .in_label(in_label),
    .result(result),
    .done(done),
    .out_addr_x(out_addr_x),
    .out_label(out_label),
    .busy(busy)
`ifdef SOM_SUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input int y, input int z, input int a, input int l);
    exp_t e;
    int s;
    s = o == 3'd0 ? y + z : o == 3'd1 ? y - z : 0;
    e.res = 9'((s + 512) % 512);
    e.ovf = o == 3'd0 ? (y + z > 511) : o == 3'd1 ? (y < z) : 1'b0;
    e.a = 3'(a);
    e.l = 3'(l);
    e.due = 0;
    return e;
  endfunction
  task automatic scramble();
    op = 3'($urandom);
    reg_y = 9'($urandom);
    reg_z = 9'($urandom);
    in_addr_x = 3'($urandom);
    in_label = 3'($urandom);
  endtask
  task automatic issue(input logic [2:0] o, input int y, input int z, input int a, input int l, input bit drop);
    exp_t e;
    op = o;
    reg_y = 9'(y);
    reg_z = 9'(z);
    in_addr_x = 3'(a);
    in_label = 3'(l);
    reg_x = 9'($urandom);
    run = 1'b1;
    @(posedge clk);
    #1;
    e = model(o, y, z, a, l);
    e.due = cyc + LAT;
    q.push_back(e);
    run = !drop;
    scramble();
    repeat (LAT) @(posedge clk);
    #1;
    run = 1'b1;
    scramble();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    run = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_result"}, result, 0);
    chk({n, "_done"}, done, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_addr"}, out_addr_x, 0);
    chk({n, "_label"}, out_label, 0);
`ifdef SOM_SUB_OVF_EN
    chk({n, "_ovf"}, ovf, 0);
`endif
  endtask
  always @(negedge clk) begin
    mon_busy = rst_n && q.size() > 0;
    mon_done = 1'b0;
    if (!rst_n) last = '{default: 0};
    else if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        mon_done = 1'b1;
        last = q.pop_front();
      end
    end
    chk("done", done, mon_done);
    chk("busy", busy, mon_busy);
    chk("result", result, last.res);
    chk("addr", out_addr_x, last.a);
    chk("label", out_label, last.l);
`ifdef SOM_SUB_OVF_EN
    chk("ovf", ovf, last.ovf);
`endif
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2:0] o;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    issue(3'd0, 5, 7, 3, 1, 1'b0);
    idle(2);
    issue(3'd1, 3, 5, 2, 4, 1'b0);
    idle(1);
    issue(3'd0, 511, 1, 7, 7, 1'b0);
    idle(1);
    issue(3'd0, 100, 28, 1, 2, 1'b0);
    issue(3'd1, 10, 20, 5, 6, 1'b0);
    idle(2);
    issue(3'd5, 9, 9, 4, 3, 1'b0);
    idle(1);
    issue(3'd1, 200, 50, 6, 5, 1'b1);
    idle(1);
    op = 3'd0;
    reg_y = 9'd100;
    reg_z = 9'd50;
    in_addr_x = 3'd2;
    in_label = 3'd3;
    run = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(3'd0, 100, 50, 2, 3));
    q[0].due = cyc + LAT;
    run = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1 chk_zero("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(LAT + 3);
    for (int i = 0; i < 40; i++) begin
      o = $urandom_range(0, 3) == 0 ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      issue(o, $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(LAT + 3);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
